// File: rtl/ptag_word_writer.sv
// Tag-stamping writer: builds {tag, datum} bus words and queues them
// through a 2-entry registered FIFO with debug counters.
module ptag_word_writer #(
  parameter int DATA_W = 28,
  parameter int TAG_W  = 4,
  parameter logic [TAG_W-1:0] DEFAULT_TAG = '0,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic [1:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W+TAG_W-1:0] out_word,
  output logic                    tag_wrap,
  output logic                    op_err,
  output logic [CNT_W-1:0]        words_out,
  output logic [CNT_W-1:0]        err_count
);

  localparam int W = DATA_W + TAG_W;

  logic [W-1:0]     q0;
  logic [W-1:0]     q1;
  logic [1:0]       cnt;
  logic [TAG_W-1:0] new_tag;
  logic             acc;
  logic             push;
  logic             pop;
  logic             op_def;
  logic             op_inc;
  logic             op_rsv;

  assign op_def = (in_op == 2'b01);
  assign op_inc = (in_op == 2'b10);
  assign op_rsv = (in_op == 2'b11);

  assign in_ready  = ~rst & (cnt < 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_word  = q0;

  assign acc  = in_valid & in_ready;
  assign push = acc & ~op_rsv;
  assign pop  = out_valid & out_ready;

  always_comb begin
    new_tag = in_tag;
    unique case (1'b1)
      op_def:  new_tag = DEFAULT_TAG;
      op_inc:  new_tag = in_tag + TAG_W'(1);
      default: new_tag = in_tag;
    endcase
  end

  // q0 is the head and drives out_word; it keeps its value when empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0  <= '0;
      q1  <= '0;
      cnt <= '0;
    end else if (push && pop) begin
      q0 <= {new_tag, in_data};
    end else if (push) begin
      if (cnt == 2'd0) q0 <= {new_tag, in_data};
      else             q1 <= {new_tag, in_data};
      cnt <= cnt + 2'd1;
    end else if (pop) begin
      if (cnt == 2'd2) q0 <= q1;
      cnt <= cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_wrap  <= 1'b0;
      op_err    <= 1'b0;
      words_out <= '0;
      err_count <= '0;
    end else begin
      tag_wrap <= acc & op_inc & (&in_tag);
      op_err   <= acc & op_rsv;
      if (pop && (words_out != '1))
        words_out <= words_out + CNT_W'(1);
      if (acc && op_rsv && (err_count != '1))
        err_count <= err_count + CNT_W'(1);
    end
  end

endmodule
